// File: rtl/ioctl_loader.sv
// ioctl_loader: replays a source image byte by byte onto the ioctl download bus; define IOCTL_LOADER_CHKSUM_EN to add the chksum output
module ioctl_loader #(
  parameter int ADDR_W    = 25,
  parameter int SETUP_CYC = 4,
  parameter int GAP_CYC   = 2,
  parameter int TAIL_CYC  = 4
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        index,
  input  logic [ADDR_W-1:0] len,
  output logic              busy,
  output logic              done,
  output logic              src_rd,
  output logic [ADDR_W-1:0] src_addr,
  input  logic [7:0]        src_data,
  input  logic              src_ack,
  output logic              ioctl_download,
  output logic [7:0]        ioctl_index,
  output logic [ADDR_W-1:0] ioctl_addr,
  output logic [7:0]        ioctl_dout,
  output logic              ioctl_wr,
  input  logic              ioctl_wait
`ifdef IOCTL_LOADER_CHKSUM_EN
  ,
  output logic [15:0]       chksum
`endif
);
  localparam int CW = 16;
  typedef enum logic [2:0] {IDLE, SETUP, FETCH, WRITE, GAP, TAIL, FIN} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [ADDR_W-1:0] len_m1;
  logic len_zero;
  assign src_addr = ioctl_addr;
  // state register; async reset lands straight in IDLE so src_rd/ioctl_wr drop at once
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  // next-state decode plus the strobes that follow the state directly
  always_comb begin
    state_n = state;
    src_rd = state == FETCH;
    ioctl_wr = state == WRITE && !ioctl_wait;
    case (state)
      IDLE:  if (start) state_n = SETUP;
      SETUP: if (cnt == CW'(SETUP_CYC - 1)) state_n = len_zero ? TAIL : FETCH;
      FETCH: if (src_ack) state_n = WRITE;
      WRITE: if (!ioctl_wait) state_n = GAP;
      GAP:   if (!ioctl_wait && cnt == CW'(GAP_CYC - 1)) state_n = ioctl_addr == len_m1 ? TAIL : FETCH;
      TAIL:  if (cnt == CW'(TAIL_CYC - 1)) state_n = FIN;
      FIN:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // phase counter restarts on every state change and freezes in GAP while the receiver stalls
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) cnt <= '0;
    else cnt <= (state_n != state) ? '0 : (state == GAP && ioctl_wait) ? cnt : cnt + 1'b1;
  // transfer registers: latched request, bus address/data, framing and handshake flags
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) begin
      busy <= 1'b0;
      done <= 1'b0;
      ioctl_download <= 1'b0;
      ioctl_index <= '0;
      ioctl_addr <= '0;
      ioctl_dout <= '0;
      len_m1 <= '0;
      len_zero <= 1'b0;
    end else begin
      done <= state == FIN;
      if (state == IDLE && start) begin
        ioctl_index <= index;
        len_m1 <= len - 1'b1;
        len_zero <= len == '0;
        ioctl_download <= 1'b1;
        busy <= 1'b1;
        ioctl_addr <= '0;
      end
      if (state == FETCH && src_ack) ioctl_dout <= src_data;
      if (state == GAP && state_n == FETCH) ioctl_addr <= ioctl_addr + 1'b1;
      if (state == TAIL && state_n == FIN) ioctl_download <= 1'b0;
      if (state == FIN) busy <= 1'b0;
    end
`ifdef IOCTL_LOADER_CHKSUM_EN
  // running mod-2^16 sum of every byte strobed onto the bus
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) chksum <= '0;
    else if (state == IDLE && start) chksum <= '0;
    else if (ioctl_wr) chksum <= chksum + 16'(ioctl_dout);
`endif
endmodule

// File: tb/tb_ioctl_loader.sv
// tb_ioctl_loader: table-driven and randomized checks of ioctl_loader against a byte-list model
module tb_ioctl_loader;
  localparam int ADDR_W = 25, SETUP_CYC = 4, GAP_CYC = 2, TAIL_CYC = 4;
  logic clk_sys = 0, reset = 1, start = 0, src_ack = 0, ioctl_wait = 0;
  logic [7:0] index = 0, src_data = 0;
  logic [ADDR_W-1:0] len = 0;
  logic busy, done, src_rd, ioctl_download, ioctl_wr;
  logic [ADDR_W-1:0] src_addr, ioctl_addr;
  logic [7:0] ioctl_index, ioctl_dout;
`ifdef IOCTL_LOADER_CHKSUM_EN
  logic [15:0] chksum;
`endif
  ioctl_loader #(.ADDR_W(ADDR_W), .SETUP_CYC(SETUP_CYC), .GAP_CYC(GAP_CYC), .TAIL_CYC(TAIL_CYC)) dut (
    .clk_sys(clk_sys), .reset(reset), .start(start), .index(index), .len(len),
    .busy(busy), .done(done), .src_rd(src_rd), .src_addr(src_addr), .src_data(src_data),
    .src_ack(src_ack), .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wr(ioctl_wr), .ioctl_wait(ioctl_wait)
`ifdef IOCTL_LOADER_CHKSUM_EN
    , .chksum(chksum)
`endif
  );
  always #5 clk_sys = ~clk_sys;

  typedef struct { logic [7:0] idx; int len; int lat; int wpct; int fill; int exp_nwr; int exp_cart; int exp_chk; } vec_t;
  typedef struct { int addr; int data; } wr_t;
  int checks = 0, errors = 0;
  logic [7:0] mem [0:255];
  int lat = 1, wpct = 0, wcnt = 0, bp_mode = 0, bp_left = 0;
  wr_t wq[$];
  int cyc = 0, nwr, ndone, dl_cyc, pre, wr_dl, bytes, cart_size, last_wr_cyc, ack_cyc1, wr_cyc1;
  logic prev_wait = 0, prev_dl = 0, prev_ack = 0;
  logic [ADDR_W-1:0] prev_addr = 0;
  logic [7:0] prev_dout = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    wq.delete();
    nwr = 0; ndone = 0; dl_cyc = 0; pre = 0; wr_dl = 0; bytes = 0; cart_size = -1;
    last_wr_cyc = 0; ack_cyc1 = -100; wr_cyc1 = -1;
  endtask

  task automatic fill_mem(input int kind);
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    if (kind == 1) begin mem[0] = 8'hA9; mem[1] = 8'h00; mem[2] = 8'h8D; mem[3] = 8'h01; end
    if (kind == 2) begin mem[1] = "A"; mem[2] = "T"; mem[3] = "A"; mem[4] = "R"; mem[5] = "I"; end
  endtask

  // source read port and receiver back-pressure, driven just after each rising edge
  always @(posedge clk_sys) begin
    #1;
    if (bp_mode != 0 && src_ack && src_addr == 1) bp_left = 5;
    if (bp_left > 0) begin ioctl_wait = 1; bp_left--; end
    else ioctl_wait = busy && wpct > 0 && $urandom_range(99) < wpct;
    if (src_rd) begin
      if (wcnt >= lat) begin src_ack = 1; src_data = mem[src_addr[7:0]]; end
      else begin src_ack = 0; wcnt++; end
    end else begin
      src_ack = 0; wcnt = 0;
    end
  end

  // receiver model and bus-rule monitor, sampled on the falling edge
  always @(negedge clk_sys) begin
    cyc++;
    if (!reset) begin
      if (ioctl_wr) begin
        chk("wr_inside_download", ioctl_download, 1);
        if (nwr > 0) chk("wr_spacing", (cyc - last_wr_cyc) >= GAP_CYC + 1, 1);
        if (nwr == 0) pre = dl_cyc;
        wq.push_back('{int'(ioctl_addr), int'(ioctl_dout)});
        if (ioctl_addr == 1) wr_cyc1 = cyc;
        last_wr_cyc = cyc;
        nwr++;
        bytes = int'(ioctl_addr) + 1;
      end
      if (ioctl_download) dl_cyc++;
      if (ioctl_wr) wr_dl = dl_cyc;
      if (src_rd && src_ack && src_addr == 1) ack_cyc1 = cyc;
      if (prev_wait && prev_dl && !prev_ack) begin
        chk("stall_addr", ioctl_addr, prev_addr);
        chk("stall_dout", ioctl_dout, prev_dout);
      end
      if (prev_dl && !ioctl_download) cart_size = (bytes + 127) / 128;
      if (done) ndone++;
    end
    prev_wait = ioctl_wait; prev_dl = ioctl_download; prev_ack = src_ack;
    prev_addr = ioctl_addr; prev_dout = ioctl_dout;
  end

  task automatic pulse_start(input logic [7:0] idx, input int n);
    @(posedge clk_sys); #1;
    start = 1; index = idx; len = ADDR_W'(n);
    @(posedge clk_sys); #1;
    start = 0; index = 8'($urandom); len = ADDR_W'($urandom);
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (ndone == 0 && n < bound) begin @(negedge clk_sys); #1; n++; end
    if (ndone == 0) chk("done_timeout", 0, 1);
    repeat (6) @(negedge clk_sys);
    #1;
  endtask

  task automatic check_bytes(input int n, input string tag);
    int sum = 0;
    chk({tag, "_nwr"}, wq.size(), n);
    for (int i = 0; i < n && i < wq.size(); i++) begin
      chk({tag, "_addr"}, wq[i].addr, i);
      chk({tag, "_data"}, wq[i].data, mem[i % 256]);
      sum += mem[i % 256];
    end
`ifdef IOCTL_LOADER_CHKSUM_EN
    chk({tag, "_chksum"}, chksum, sum % 65536);
`endif
  endtask

  task automatic run_xfer(input vec_t v);
    clear_mon();
    fill_mem(v.fill);
    lat = v.lat; wpct = v.wpct;
    pulse_start(v.idx, v.len);
    chk("busy_after_start", busy, 1);
    chk("download_after_start", ioctl_download, 1);
    wait_done(40 * v.len + 200);
    check_bytes(v.len, "xfer");
    chk("nwr", nwr, v.exp_nwr);
    chk("done_once", ndone, 1);
    chk("busy_end", busy, 0);
    chk("download_end", ioctl_download, 0);
    chk("index", ioctl_index, v.idx);
    chk("cart_size", cart_size, v.exp_cart);
    if (v.len > 0) begin
      chk("setup_before_first_wr", pre >= SETUP_CYC, 1);
      chk("tail_after_last_wr", (dl_cyc - wr_dl) >= TAIL_CYC, 1);
    end else chk("empty_download_len", dl_cyc, SETUP_CYC + TAIL_CYC);
`ifdef IOCTL_LOADER_CHKSUM_EN
    if (v.exp_chk >= 0) chk("chksum_const", chksum, v.exp_chk);
`endif
  endtask

  initial begin
    vec_t vt[7];
    int n;
    vt[0] = '{8'd0, 4, 1, 0, 1, 4, 1, 16'h0137};
    vt[1] = '{8'd1, 0, 1, 0, 0, 0, 0, 0};
    vt[2] = '{8'd1, 130, 1, 0, 2, 130, 2, -1};
    vt[3] = '{8'd3, 7, 0, 30, 0, 7, 1, -1};
    vt[4] = '{8'd2, 20, 2, 50, 0, 20, 1, -1};
    vt[5] = '{8'd4, 1, 3, 20, 0, 1, 1, -1};
    vt[6] = '{8'd5, 5, 0, 0, 0, 5, 1, -1};
    fill_mem(0);
    clear_mon();
    repeat (3) @(negedge clk_sys);
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_src_rd", src_rd, 0);
    chk("rst_download", ioctl_download, 0); chk("rst_wr", ioctl_wr, 0);
    chk("rst_addr", ioctl_addr, 0); chk("rst_index", ioctl_index, 0); chk("rst_dout", ioctl_dout, 0);
    @(posedge clk_sys); #1 reset = 0;
    // reset while fetching: everything drops before the next edge, no done follows
    clear_mon();
    lat = 3; wpct = 0;
    pulse_start(8'h7, 10);
    n = 0;
    while (!src_rd && n < 50) begin @(negedge clk_sys); #1; n++; end
    chk("reached_fetch", src_rd, 1);
    #2 reset = 1;
    #1;
    chk("midrst_busy", busy, 0); chk("midrst_download", ioctl_download, 0);
    chk("midrst_src_rd", src_rd, 0); chk("midrst_wr", ioctl_wr, 0);
    chk("midrst_index", ioctl_index, 0); chk("midrst_addr", ioctl_addr, 0);
    @(posedge clk_sys); #1 reset = 0;
    repeat (20) @(negedge clk_sys);
    chk("midrst_no_done", ndone, 0);
    chk("midrst_idle_download", ioctl_download, 0);
    for (int i = 0; i < 7; i++) run_xfer(vt[i]);
    for (int r = 0; r < 4; r++) begin
      vec_t v;
      v.idx = 8'($urandom); v.len = $urandom_range(1, 40); v.lat = $urandom_range(0, 3);
      v.wpct = $urandom_range(0, 60); v.fill = 0; v.exp_nwr = v.len; v.exp_cart = 1; v.exp_chk = -1;
      run_xfer(v);
    end
    // back-pressure: 5 stall cycles from the WRITE of byte 1
    clear_mon();
    fill_mem(0);
    lat = 1; wpct = 0; bp_mode = 1;
    pulse_start(8'h2, 3);
    wait_done(300);
    bp_mode = 0;
    check_bytes(3, "bp");
    chk("bp_strobe_delay", wr_cyc1 - ack_cyc1, 6);
    chk("bp_done_once", ndone, 1);
    // start pulsed during GAP is ignored
    clear_mon();
    fill_mem(0);
    lat = 0; wpct = 0;
    pulse_start(8'h5, 3);
    n = 0;
    while (nwr < 1 && n < 100) begin @(negedge clk_sys); #1; n++; end
    chk("ign_first_wr", nwr, 1);
    pulse_start(8'h9, 7);
    wait_done(300);
    repeat (30) @(negedge clk_sys);
    check_bytes(3, "ign");
    chk("ign_done_once", ndone, 1);
    chk("ign_index", ioctl_index, 8'h5);
    chk("ign_busy", busy, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
